// File: rtl/stopwatch_controller.sv
// Control FSM for the mm:ss stopwatch: key conditioning, tick generation,
// clear/preset loads and end-of-count handling for the BCD counter chain.
module stopwatch_controller #(
   parameter int unsigned BASE_DIV     = 5000000,
   parameter int unsigned SLOW_RATIO   = 10,
   parameter int unsigned DEBOUNCE     = 500000,
   parameter logic [15:0] PRESET_VALUE = 16'h5900,
   parameter bit          STOP_AT_MAX  = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  KEY,
   input  logic        AT_MAX,
   output logic        TICK,
   output logic        LOAD,
   output logic [15:0] LOAD_VALUE,
   output logic        RUNNING,
   output logic        FAST
);

   localparam int unsigned PRE_W  = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam int unsigned SLOW_W = (SLOW_RATIO > 1) ? $clog2(SLOW_RATIO) : 1;
   localparam int unsigned DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   typedef enum logic [1:0] {
      STOPPED,
      RUN,
      LOADING
   } state_t;

   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       deb;
   logic [DEB_W-1:0] deb_cnt [4];
   logic [2:0]       deb_prev;
   logic             press_clear;
   logic             press_start;
   logic             press_preset;

   state_t            state;
   state_t            state_d;
   logic              tick_d;
   logic              load_d;
   logic [15:0]       load_value_d;
   logic              running_d;
   logic              fast_d;
   logic [PRE_W-1:0]  presc;
   logic [PRE_W-1:0]  presc_d;
   logic [SLOW_W-1:0] slow;
   logic [SLOW_W-1:0] slow_d;
   logic              base_c;
   logic              tick_due_c;

   // Two-flop synchroniser; flops idle at the released level
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1 <= 4'hF;
         sync2 <= 4'hF;
      end else begin
         sync1 <= KEY;
         sync2 <= sync1;
      end
   end

   // Debounce: accept a new level only after DEBOUNCE consecutive differing samples
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         deb <= 4'hF;
         for (int i = 0; i < 4; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEBOUNCE - 1)) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Registered press pulses on debounced 1->0; the fast key is level-only
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         deb_prev     <= 3'b111;
         press_clear  <= 1'b0;
         press_start  <= 1'b0;
         press_preset <= 1'b0;
      end else begin
         deb_prev     <= {deb[3], deb[1], deb[0]};
         press_clear  <= deb_prev[0] & ~deb[0];
         press_start  <= deb_prev[1] & ~deb[1];
         press_preset <= deb_prev[2] & ~deb[3];
      end
   end

   // Next-state, tick and load decisions
   always_comb begin
      state_d      = state;
      tick_d       = 1'b0;
      load_d       = 1'b0;
      load_value_d = LOAD_VALUE;
      presc_d      = presc;
      slow_d       = slow;
      base_c       = 1'b0;
      tick_due_c   = 1'b0;

      case (state)
         STOPPED: begin
            if (press_clear) begin
               load_d       = 1'b1;
               load_value_d = 16'h0000;
               state_d      = LOADING;
            end else if (press_preset) begin
               load_d       = 1'b1;
               load_value_d = PRESET_VALUE;
               state_d      = LOADING;
            end else if (press_start && !(STOP_AT_MAX && AT_MAX)) begin
               state_d = RUN;
               presc_d = '0;
               slow_d  = '0;
            end
         end

         RUN: begin
            if (presc == PRE_W'(BASE_DIV - 1)) begin
               presc_d = '0;
               base_c  = 1'b1;
            end else begin
               presc_d = presc + PRE_W'(1);
            end
            if (base_c) begin
               slow_d = (slow == SLOW_W'(SLOW_RATIO - 1)) ? '0 : slow + SLOW_W'(1);
            end
            tick_due_c = base_c && (FAST || (slow == SLOW_W'(SLOW_RATIO - 1)));

            if (press_clear) begin
               load_d       = 1'b1;
               load_value_d = 16'h0000;
               state_d      = LOADING;
            end else if (press_preset) begin
               load_d       = 1'b1;
               load_value_d = PRESET_VALUE;
               state_d      = LOADING;
            end else begin
               // At 59:59 a due tick becomes a halt instead of a wrap
               if (tick_due_c) begin
                  if (STOP_AT_MAX && AT_MAX) begin
                     state_d = STOPPED;
                  end else begin
                     tick_d = 1'b1;
                  end
               end
               if (press_start) begin
                  state_d = STOPPED;
               end
            end
         end

         LOADING: begin
            state_d = STOPPED;
         end

         default: begin
            state_d = STOPPED;
         end
      endcase

      running_d = (state_d == RUN);
      fast_d    = (state_d == RUN) && !deb[2];
   end

   // State and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= STOPPED;
         TICK       <= 1'b0;
         LOAD       <= 1'b0;
         LOAD_VALUE <= 16'h0000;
         RUNNING    <= 1'b0;
         FAST       <= 1'b0;
         presc      <= '0;
         slow       <= '0;
      end else begin
         state      <= state_d;
         TICK       <= tick_d;
         LOAD       <= load_d;
         LOAD_VALUE <= load_value_d;
         RUNNING    <= running_d;
         FAST       <= fast_d;
         presc      <= presc_d;
         slow       <= slow_d;
      end
   end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller: directed latency/priority
// scenarios plus randomized key traffic against a behavioural model.
module tb_stopwatch_controller;

   localparam int unsigned TB_BASE = 4;
   localparam int unsigned TB_SLOW = 3;
   localparam int unsigned TB_DEB  = 3;

   logic        CLK;
   logic        RST;
   logic [3:0]  KEY;
   logic [3:0]  KEY2;
   logic        AT_MAX;
   logic        AT_MAX2;
   logic        TICK, LOAD, RUNNING, FAST;
   logic [15:0] LOAD_VALUE;
   logic        TICK2, LOAD2, RUNNING2, FAST2;
   logic [15:0] LOAD_VALUE2;

   int checks = 0;
   int errors = 0;

   stopwatch_controller #(
      .BASE_DIV(TB_BASE), .SLOW_RATIO(TB_SLOW), .DEBOUNCE(TB_DEB),
      .PRESET_VALUE(16'h5900), .STOP_AT_MAX(1'b1)
   ) dut (
      .CLK(CLK), .RST(RST), .KEY(KEY), .AT_MAX(AT_MAX), .TICK(TICK), .LOAD(LOAD),
      .LOAD_VALUE(LOAD_VALUE), .RUNNING(RUNNING), .FAST(FAST)
   );

   stopwatch_controller #(
      .BASE_DIV(TB_BASE), .SLOW_RATIO(TB_SLOW), .DEBOUNCE(TB_DEB),
      .PRESET_VALUE(16'h5900), .STOP_AT_MAX(1'b0)
   ) dut_wrap (
      .CLK(CLK), .RST(RST), .KEY(KEY2), .AT_MAX(AT_MAX2), .TICK(TICK2), .LOAD(LOAD2),
      .LOAD_VALUE(LOAD_VALUE2), .RUNNING(RUNNING2), .FAST(FAST2)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Behavioural model: key levels accepted after DEBOUNCE equal samples,
   // ticks scheduled arithmetically from the number of cycles spent running.
   typedef enum logic [1:0] {M_IDLE, M_RUN, M_LOAD} mode_t;
   typedef struct packed {
      logic [TB_DEB+1:0][3:0] samp;
      logic [3:0][3:0]        dvh;
      mode_t                  mode;
      int                     k;
      logic                   tick;
      logic                   load;
      logic                   run;
      logic                   fast;
      logic [15:0]            lv;
   } model_t;

   model_t m;

   function automatic model_t model_step(input model_t s, input logic [3:0] key_in,
                                         input logic at_max_in);
      model_t     n;
      logic [3:0] all0, all1, ev;
      logic       due;
      n = s;
      for (int i = TB_DEB + 1; i > 0; i--) n.samp[i] = s.samp[i-1];
      n.samp[0] = key_in;
      all0 = 4'hF;
      all1 = 4'hF;
      for (int i = 2; i <= TB_DEB + 1; i++) begin
         all0 = all0 & ~n.samp[i];
         all1 = all1 & n.samp[i];
      end
      for (int i = 3; i > 0; i--) n.dvh[i] = s.dvh[i-1];
      n.dvh[0] = (s.dvh[0] & ~all0) | all1;
      ev = n.dvh[3] & ~n.dvh[2];
      n.tick = 1'b0;
      n.load = 1'b0;
      case (s.mode)
         M_LOAD: n.mode = M_IDLE;
         M_IDLE: begin
            if (ev[0]) begin n.load = 1'b1; n.lv = 16'h0000; n.mode = M_LOAD; end
            else if (ev[3]) begin n.load = 1'b1; n.lv = 16'h5900; n.mode = M_LOAD; end
            else if (ev[1] && !at_max_in) begin n.mode = M_RUN; n.k = 0; end
         end
         default: begin
            n.k = s.k + 1;
            due = ((n.k % TB_BASE) == 0) && (s.fast || (((n.k / TB_BASE) % TB_SLOW) == 0));
            if (ev[0]) begin n.load = 1'b1; n.lv = 16'h0000; n.mode = M_LOAD; end
            else if (ev[3]) begin n.load = 1'b1; n.lv = 16'h5900; n.mode = M_LOAD; end
            else begin
               if (due && at_max_in) n.mode = M_IDLE;
               else n.tick = due;
               if (ev[1]) n.mode = M_IDLE;
            end
         end
      endcase
      n.run  = (n.mode == M_RUN);
      n.fast = n.run && !n.dvh[1][2];
      return n;
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST) m <= '{samp: '1, dvh: '1, mode: M_IDLE, k: 0, tick: 1'b0, load: 1'b0,
                      run: 1'b0, fast: 1'b0, lv: 16'h0000};
      else     m <= model_step(m, KEY, AT_MAX);
   end

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; KEY = 4'hF; KEY2 = 4'hF; AT_MAX = 1'b0; AT_MAX2 = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      logic [19:0] got;
      do_reset();
      for (int j = 0; j < 50; j++) begin
         @(negedge CLK);
         got = {TICK, LOAD, LOAD_VALUE, RUNNING, FAST};
         checks++;
         if (got !== 20'h0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %h required 00000", j, got);
         end
      end
   endtask

   task automatic test_start_stop();
      logic exp_tick;
      do_reset();
      @(negedge CLK); KEY[1] = 1'b0;
      for (int j = 0; j <= 40; j++) begin
         @(negedge CLK);
         if (j == 9) KEY[1] = 1'b1;
         if (j == 5) begin
            checks++;
            if (RUNNING !== 1'b0) begin errors++; $display("FAIL start_early: RUNNING=%b required 0", RUNNING); end
         end
         if (j == 6) begin
            checks++;
            if (RUNNING !== 1'b1) begin errors++; $display("FAIL start_latency: RUNNING=%b required 1", RUNNING); end
         end
         exp_tick = (j >= 18) && (((j - 18) % 12) == 0);
         checks++;
         if (TICK !== exp_tick) begin errors++; $display("FAIL slow_tick j=%0d: TICK=%b required %b", j, TICK, exp_tick); end
      end
      KEY[1] = 1'b0;
      for (int j = 0; j <= 40; j++) begin
         @(negedge CLK);
         if (j == 5) KEY[1] = 1'b1;
         exp_tick = (j < 6) && (((35 + j) % 12) == 0);
         checks++;
         if (TICK !== exp_tick) begin errors++; $display("FAIL stop_tick j=%0d: TICK=%b required %b", j, TICK, exp_tick); end
         if (j == 5 || j == 6) begin
            checks++;
            if (RUNNING !== (j == 5)) begin errors++; $display("FAIL stop_latency j=%0d: RUNNING=%b", j, RUNNING); end
         end
      end
   endtask

   task automatic test_fast();
      int last_tick;
      last_tick = -100;
      do_reset();
      @(negedge CLK); KEY[1] = 1'b0;
      for (int j = 0; j <= 140; j++) begin
         @(negedge CLK);
         if (j == 4) KEY[1] = 1'b1;
         if (j == 25) KEY[2] = 1'b0;
         if (j == 80) KEY[2] = 1'b1;
         if (j == 30 || j == 31) begin
            checks++;
            if (FAST !== (j == 31)) begin errors++; $display("FAIL fast_latency j=%0d: FAST=%b", j, FAST); end
         end
         checks++;
         if ({TICK, FAST} !== {m.tick, m.fast}) begin
            errors++;
            $display("FAIL fast_model j=%0d: TICK,FAST=%b%b required %b%b", j, TICK, FAST, m.tick, m.fast);
         end
         if (TICK === 1'b1) begin
            if (last_tick >= 0) begin
               checks++;
               if (j - last_tick < 4) begin errors++; $display("FAIL double_tick: gap %0d required >=4", j - last_tick); end
            end
            if (last_tick >= 36 && j <= 80) begin
               checks++;
               if (j - last_tick != 4) begin errors++; $display("FAIL fast_period: gap %0d required 4", j - last_tick); end
            end
            if (last_tick >= 100) begin
               checks++;
               if (j - last_tick != 12) begin errors++; $display("FAIL slow_period: gap %0d required 12", j - last_tick); end
            end
            last_tick = j;
         end
      end
   endtask

   task automatic test_preset();
      int loads;
      do_reset();
      @(negedge CLK); KEY[1] = 1'b0;
      for (int j = 0; j <= 40; j++) begin
         @(negedge CLK);
         if (j == 4)  KEY[1] = 1'b1;
         if (j == 23) KEY[3] = 1'b0;
         if (j == 28) KEY[3] = 1'b1;
         if (j == 18) begin
            checks++;
            if (TICK !== 1'b1) begin errors++; $display("FAIL pre_tick: TICK=%b required 1", TICK); end
         end
         if (j == 29) begin
            checks++;
            if ({RUNNING, LOAD} !== 2'b10) begin errors++; $display("FAIL preset_before: RUNNING,LOAD=%b required 10", {RUNNING, LOAD}); end
         end
         if (j == 30) begin
            checks++;
            if ({LOAD, TICK, RUNNING, LOAD_VALUE} !== {3'b100, 16'h5900}) begin
               errors++;
               $display("FAIL preset_load: LOAD,TICK,RUNNING=%b%b%b VALUE=%h required 100 5900", LOAD, TICK, RUNNING, LOAD_VALUE);
            end
         end
         if (j == 31) begin
            checks++;
            if ({LOAD, RUNNING} !== 2'b00) begin errors++; $display("FAIL preset_after: LOAD,RUNNING=%b required 00", {LOAD, RUNNING}); end
         end
      end
      loads = 0;
      KEY[0] = 1'b0; KEY[3] = 1'b0;
      for (int j = 0; j <= 20; j++) begin
         @(negedge CLK);
         if (j == 4) begin KEY[0] = 1'b1; KEY[3] = 1'b1; end
         if (LOAD === 1'b1) loads++;
         if (j == 6) begin
            checks++;
            if ({LOAD, LOAD_VALUE} !== {1'b1, 16'h0000}) begin
               errors++;
               $display("FAIL clear_priority: LOAD=%b VALUE=%h required 1 0000", LOAD, LOAD_VALUE);
            end
         end
      end
      checks++;
      if (loads != 1) begin errors++; $display("FAIL clear_pulses: %0d LOAD cycles required 1", loads); end
   endtask

   task automatic test_at_max();
      do_reset();
      @(negedge CLK); KEY[1] = 1'b0;
      for (int j = 0; j <= 40; j++) begin
         @(negedge CLK);
         if (j == 4)  KEY[1] = 1'b1;
         if (j == 20) AT_MAX = 1'b1;
         if (j == 29 || j == 30) begin
            checks++;
            if (RUNNING !== (j == 29)) begin errors++; $display("FAIL at_max_stop j=%0d: RUNNING=%b", j, RUNNING); end
         end
         if (j >= 19) begin
            checks++;
            if (TICK !== 1'b0) begin errors++; $display("FAIL at_max_tick j=%0d: TICK=%b required 0", j, TICK); end
         end
      end
      KEY[1] = 1'b0;
      for (int j = 0; j <= 20; j++) begin
         @(negedge CLK);
         if (j == 4) KEY[1] = 1'b1;
         checks++;
         if (RUNNING !== 1'b0) begin errors++; $display("FAIL at_max_start j=%0d: RUNNING=%b required 0", j, RUNNING); end
      end
      AT_MAX = 1'b0;
      AT_MAX2 = 1'b1;
      KEY2[1] = 1'b0;
      for (int j = 0; j <= 30; j++) begin
         @(negedge CLK);
         if (j == 4) KEY2[1] = 1'b1;
         if (j == 5 || j == 6 || j == 19) begin
            checks++;
            if (RUNNING2 !== (j != 5)) begin errors++; $display("FAIL wrap_running j=%0d: RUNNING=%b", j, RUNNING2); end
         end
         if (j == 17 || j == 18 || j == 30) begin
            checks++;
            if (TICK2 !== (j != 17)) begin errors++; $display("FAIL wrap_tick j=%0d: TICK=%b", j, TICK2); end
         end
      end
      AT_MAX2 = 1'b0;
   endtask

   task automatic test_glitch_reset();
      int   g;
      logic load_seen;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         g = $urandom_range(1, TB_DEB - 1);
         load_seen = 1'b0;
         @(negedge CLK); KEY[0] = 1'b0;
         for (int j = 0; j < 20; j++) begin
            @(negedge CLK);
            if (j == g - 1) KEY[0] = 1'b1;
            if (LOAD === 1'b1) load_seen = 1'b1;
         end
         checks++;
         if (load_seen !== 1'b0) begin errors++; $display("FAIL glitch len %0d: LOAD seen=%b required 0", g, load_seen); end
      end
      @(negedge CLK); KEY[3] = 1'b0;
      for (int j = 0; j <= 6; j++) begin
         @(negedge CLK);
         if (j == 4) KEY[3] = 1'b1;
      end
      checks++;
      if ({LOAD, LOAD_VALUE} !== {1'b1, 16'h5900}) begin
         errors++;
         $display("FAIL load_pre_rst: LOAD=%b VALUE=%h required 1 5900", LOAD, LOAD_VALUE);
      end
      #1 RST = 1'b1;
      #1;
      checks++;
      if ({TICK, LOAD, LOAD_VALUE, RUNNING, FAST} !== 20'h0) begin
         errors++;
         $display("FAIL rst_abort: LOAD=%b VALUE=%h required 0 0000", LOAD, LOAD_VALUE);
      end
      @(negedge CLK); RST = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge CLK);
         checks++;
         if ({LOAD, LOAD_VALUE} !== 17'h0) begin errors++; $display("FAIL rst_residue j=%0d: LOAD=%b VALUE=%h", j, LOAD, LOAD_VALUE); end
      end
   endtask

   task automatic test_random_traffic();
      int          hold [4];
      logic [19:0] got, exp;
      do_reset();
      for (int i = 0; i < 4; i++) hold[i] = $urandom_range(5, 40);
      for (int n = 0; n < 4000; n++) begin
         @(negedge CLK);
         got = {TICK, LOAD, LOAD_VALUE, RUNNING, FAST};
         exp = {m.tick, m.load, m.lv, m.run, m.fast};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL random cycle %0d: got %h required %h", n, got, exp); end
         checks++;
         if (TICK === 1'b1 && LOAD === 1'b1) begin errors++; $display("FAIL tick_load_overlap cycle %0d: TICK=1 LOAD=1", n); end
         for (int i = 0; i < 4; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               KEY[i] = ~KEY[i];
               if (KEY[i] == 1'b0) hold[i] = (i == 2) ? $urandom_range(1, 40) : $urandom_range(1, 6);
               else hold[i] = (i == 1) ? $urandom_range(8, 60) :
                              (i == 2) ? $urandom_range(5, 60) : $urandom_range(30, 200);
            end
         end
         if ($urandom_range(0, 59) == 0) AT_MAX = ~AT_MAX;
      end
      KEY = 4'hF;
      AT_MAX = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RST = 1'b0; KEY = 4'hF; KEY2 = 4'hF; AT_MAX = 1'b0; AT_MAX2 = 1'b0;
      test_reset();
      test_start_stop();
      test_fast();
      test_preset();
      test_at_max();
      test_glitch_reset();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
